spi_slave_os: RTL and testbench
===============================

Name: spi_slave_os

Overview:
- Oversampled SPI slave (responder) in the system `clk` domain; the receiving end of the SPI master's bus.
- Synchronises `s_clk`, `slave_select` and `mosi`, and detects SCLK edges.
- Supports all four CPOL/CPHA modes, MSB first.
- Exchanges parallel words with system logic through a tx valid/ready holding register and an rx strobe.
- Allows back-to-back words while `slave_select` stays low.

Parameters:
- data_width, 8, word length in bits (≥2).
- sync_stages, 2, synchroniser flops on `s_clk`, `slave_select` and `mosi` (≥2).

Ports:
- clk  in  1  system clock; must run ≥4× the `s_clk` frequency.
- rst_n  in  1  synchronous active-low reset.
- CPOL  in  1  SCLK idle level; static while `slave_select` is low.
- CPHA  in  1  0 = sample on leading edge, 1 = sample on trailing edge; static while `slave_select` is low.
- s_clk  in  1  SPI clock from the master (asynchronous).
- slave_select  in  1  active-low chip select (asynchronous).
- mosi  in  1  serial data in (asynchronous).
- miso  out  1  serial data out; 0 when deselected.
- s_din  in  data_width  tx word.
- tx_valid  in  1  tx word offered.
- tx_ready  out  1  holding register empty.
- s_dout  out  data_width  last complete received word; held until the next word completes.
- rx_valid  out  1  one-cycle pulse when `s_dout` updates.
- done_tick  out  1  one-cycle pulse at word completion, coincident with `rx_valid`.
- busy  out  1  high in XFER.
- tx_underrun  out  1  one-cycle pulse when a word load finds no tx data.

Behaviour:
- Reset (rst_n low at a clk edge) values:
  - all outputs 0 except tx_ready=1;
  - FSM to IDLE; holding register empty; shift registers, bit count and synchronisers cleared.
  - Reset mid-transfer discards the partial word, with no pulses.
- Edges:
  - leading edge = synchronised `s_clk` leaving the CPOL level; trailing edge = returning to it.
  - sample edge = leading if CPHA=0, else trailing; shift edge = the other one.
  - mosi passes through the same number of sync stages, so it is sampled aligned with the clock edge.
- Latency: pin edge to action ≤ sync_stages+1 clk cycles; outputs are registered and visible the cycle after the action.
- Load (at entry to XFER and at each word boundary):
  - if the holding register is full, copy it to tx_sr and empty the holding register;
  - else if tx_valid is high that same cycle, bypass s_din directly into tx_sr;
  - else load all zeros and pulse tx_underrun.
- Holding register: write when tx_valid && tx_ready; tx_ready = holding register empty.
- FSM:
  - IDLE → XFER on synchronised slave_select falling: load, bit count=0, busy=1. For CPHA=0, miso = tx_sr MSB immediately.
  - XFER, sample edge: rx_sr shifts left with mosi into the LSB; bit count +1.
  - XFER, shift edge (CPHA=0): tx_sr shifts left.
  - XFER, shift edge (CPHA=1): a first_bit flag suppresses the shift on the word's first leading edge (MSB already on miso); later shift edges shift left.
  - XFER, sample edge with count = data_width-1:
    - s_dout ← completed word; rx_valid=done_tick=1 for one cycle; count=0;
    - CPHA=0: load for the next word at the following trailing edge, in place of the shift;
    - CPHA=1: load immediately and set first_bit.
  - XFER → IDLE on synchronised slave_select rising, at any bit count:
    - a partial word is discarded with no rx_valid;
    - the tx word in tx_sr is lost; the holding register is untouched;
    - miso=0, busy=0.
- Simultaneous events:
  - slave_select rising in the same cycle as the final sample edge completes the word first (rx_valid pulses), then goes to IDLE.
  - A tx write in the same cycle as a load from a full holding register: the load takes the old word and the new word is written.
- Glitches: SCLK edges while in IDLE are ignored.
- No rx backpressure: an unread s_dout is overwritten.

Decomposition:
- Shared package spi_pkg:
  - localparams for the mode encoding (MODE0..MODE3 as {CPOL,CPHA});
  - FSM state encoding (IDLE, XFER);
  - the default data_width.
- One sub-module, spi_sync_edge: an N-stage synchroniser plus previous-value register. It outputs the synchronised level, rise and fall; instantiate it for s_clk, slave_select and mosi (mosi uses the level only).

Test Plan:
- Mode 0 (CPOL=0, CPHA=0), clk = 8× s_clk, s_din=8'hA5 preloaded, master sends 8'h3C → s_dout=8'h3C with one rx_valid/done_tick pulse; master captures 8'hA5 on miso.
- Modes 1, 2 and 3 with the same data → identical results; miso stable at every master sample edge.
- Back-to-back, mode 3: master sends 8'h11, 8'h22 under one slave_select; s_din 8'hC3 then 8'h7E written during the first word → two rx_valid pulses (8'h11, 8'h22); master receives 8'hC3, 8'h7E; tx_underrun stays 0.
- Underrun: no tx write before slave_select falls → tx_underrun pulses once; master receives 8'h00; rx still correct.
- Abort: slave_select rises after 5 bits → no rx_valid; s_dout keeps its previous value; busy=0 and miso=0 within sync_stages+2 cycles. A following full transfer of 8'h96 is received correctly.
- Reset mid-word (rst_n low 1 cycle after bit 3) → all outputs at reset values next cycle; tx_ready=1; the next transfer starts from bit 0.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared constants for the oversampled SPI slave.
package spi_pkg;

   localparam int DATA_WIDTH_DEF = 8;

   // Mode encoding is {CPOL, CPHA}.
   localparam logic [1:0] MODE0 = 2'b00;
   localparam logic [1:0] MODE1 = 2'b01;
   localparam logic [1:0] MODE2 = 2'b10;
   localparam logic [1:0] MODE3 = 2'b11;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_XFER = 1'b1;

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchroniser with a previous-value register for edge strobes.
module spi_sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_d,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic [STAGES-1:0] r_sync;
   logic              r_prev;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sync <= '0;
         r_prev <= 1'b0;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], i_d};
         r_prev <= r_sync[STAGES-1];
      end
   end

   assign o_level = r_sync[STAGES-1];
   assign o_rise  = r_sync[STAGES-1] & ~r_prev;
   assign o_fall  = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/spi_slave_os.sv
// Oversampled SPI slave: all CPOL/CPHA modes, MSB first, back-to-back words.
// Pins are synchronised in clk; SCLK edges become one-cycle strobes.
module spi_slave_os
   import spi_pkg::*;
#(
   parameter int data_width  = DATA_WIDTH_DEF,
   parameter int sync_stages = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  CPOL,
   input  logic                  CPHA,
   input  logic                  s_clk,
   input  logic                  slave_select,
   input  logic                  mosi,
   output logic                  miso,
   input  logic [data_width-1:0] s_din,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   output logic [data_width-1:0] s_dout,
   output logic                  rx_valid,
   output logic                  done_tick,
   output logic                  busy,
   output logic                  tx_underrun
);

   localparam int            CW   = $clog2(data_width);
   localparam logic [CW-1:0] LAST = CW'(data_width - 1);

   logic w_sck_rise, w_sck_fall, w_unused_sck;
   logic w_ss_rise, w_ss_fall, w_unused_ss;
   logic w_mosi, w_unused_mosi_r, w_unused_mosi_f;
   logic w_sample, w_shift, w_last, w_load;
   logic [data_width-1:0] w_ld_word;

   logic [0:0]            r_state;
   logic [data_width-1:0] r_hold;
   logic                  r_hold_full;
   logic [data_width-1:0] r_tx_sr;
   logic [data_width-1:0] r_rx_sr;
   logic [CW-1:0]         r_cnt;
   logic                  r_first;
   logic                  r_reload;
   logic [data_width-1:0] r_dout;
   logic                  r_rx_valid;
   logic                  r_underrun;

   spi_sync_edge #(.STAGES(sync_stages)) u_sck (
      .clk(clk), .rst_n(rst_n), .i_d(s_clk),
      .o_level(w_unused_sck), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
   );

   spi_sync_edge #(.STAGES(sync_stages)) u_ss (
      .clk(clk), .rst_n(rst_n), .i_d(slave_select),
      .o_level(w_unused_ss), .o_rise(w_ss_rise), .o_fall(w_ss_fall)
   );

   spi_sync_edge #(.STAGES(sync_stages)) u_mosi (
      .clk(clk), .rst_n(rst_n), .i_d(mosi),
      .o_level(w_mosi), .o_rise(w_unused_mosi_r), .o_fall(w_unused_mosi_f)
   );

   // Sample is the rising SCLK edge in modes 0/3, falling in modes 1/2.
   always_comb begin
      w_sample = 1'b0;
      w_shift  = 1'b0;
      unique case ({CPOL, CPHA})
         MODE0, MODE3: begin
            w_sample = w_sck_rise;
            w_shift  = w_sck_fall;
         end
         MODE1, MODE2: begin
            w_sample = w_sck_fall;
            w_shift  = w_sck_rise;
         end
         default: ;
      endcase
   end

   assign w_last = w_sample && (r_cnt == LAST);

   // A deselect wins over a boundary load: tx_sr is dropped anyway.
   assign w_load = (r_state == ST_IDLE) ? w_ss_fall
                 : !w_ss_rise && ((CPHA && w_last) ||
                                  (!CPHA && w_shift && r_reload));

   assign w_ld_word = r_hold_full ? r_hold
                    : (tx_valid ? s_din : '0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_hold      <= '0;
         r_hold_full <= 1'b0;
         r_tx_sr     <= '0;
         r_rx_sr     <= '0;
         r_cnt       <= '0;
         r_first     <= 1'b0;
         r_reload    <= 1'b0;
         r_dout      <= '0;
         r_rx_valid  <= 1'b0;
         r_underrun  <= 1'b0;
      end else begin
         r_rx_valid <= 1'b0;
         r_underrun <= w_load && !r_hold_full && !tx_valid;

         if (w_load && r_hold_full) begin
            r_hold_full <= 1'b0;
         end else if (tx_valid && !r_hold_full && !w_load) begin
            r_hold      <= s_din;
            r_hold_full <= 1'b1;
         end

         unique case (r_state)
            ST_IDLE: begin
               if (w_ss_fall) begin
                  r_state  <= ST_XFER;
                  r_cnt    <= '0;
                  r_tx_sr  <= w_ld_word;
                  r_first  <= CPHA;
                  r_reload <= 1'b0;
               end
            end
            ST_XFER: begin
               if (w_sample) begin
                  r_rx_sr <= {r_rx_sr[data_width-2:0], w_mosi};
                  if (w_last) begin
                     r_cnt      <= '0;
                     r_dout     <= {r_rx_sr[data_width-2:0], w_mosi};
                     r_rx_valid <= 1'b1;
                     r_reload   <= !CPHA;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
               if (w_load) begin
                  r_tx_sr  <= w_ld_word;
                  r_first  <= CPHA;
                  r_reload <= 1'b0;
               end else if (w_shift) begin
                  if (r_first) r_first <= 1'b0;
                  else         r_tx_sr <= r_tx_sr << 1;
               end
               if (w_ss_rise) begin
                  r_state  <= ST_IDLE;
                  r_cnt    <= '0;
                  r_first  <= 1'b0;
                  r_reload <= 1'b0;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign busy        = (r_state == ST_XFER);
   assign miso        = busy & r_tx_sr[data_width-1];
   assign tx_ready    = ~r_hold_full;
   assign s_dout      = r_dout;
   assign rx_valid    = r_rx_valid;
   assign done_tick   = r_rx_valid;
   assign tx_underrun = r_underrun;

endmodule

// File: tb/tb_spi_slave_os.sv
// Directed bench for spi_slave_os: bit-banged SPI master, rx scoreboard,
// immediate assertions at every comparison point.
module tb_spi_slave_os;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cpol = 1'b0;
   logic       cpha = 1'b0;
   logic       s_clk = 1'b0;
   logic       slave_select = 1'b1;
   logic       mosi = 1'b0;
   logic [7:0] s_din = '0;
   logic       tx_valid = 1'b0;
   logic       miso, tx_ready, rx_valid, done_tick, busy, tx_underrun;
   logic [7:0] s_dout;

   int         n_chk = 0;
   int         n_pass = 0;
   int         rx_seen = 0;
   int         und_seen = 0;
   logic [7:0] exp_rx[$];

   spi_slave_os #(.data_width(8), .sync_stages(2)) dut (
      .clk(clk), .rst_n(rst_n), .CPOL(cpol), .CPHA(cpha),
      .s_clk(s_clk), .slave_select(slave_select), .mosi(mosi),
      .miso(miso), .s_din(s_din), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .s_dout(s_dout), .rx_valid(rx_valid),
      .done_tick(done_tick), .busy(busy), .tx_underrun(tx_underrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   always @(negedge clk) begin
      if (rx_valid || done_tick)
         chk("done_with_rx", 32'(done_tick), 32'(rx_valid));
      if (rx_valid) begin
         rx_seen++;
         if (exp_rx.size() == 0)
            chk("rx_unexpected", 32'(s_dout), 32'hFFFF);
         else
            chk("rx_data", 32'(s_dout), 32'(exp_rx.pop_front()));
      end
      if (tx_underrun) und_seen++;
   end

   task automatic half();
      repeat (4) @(negedge clk);
   endtask

   task automatic set_mode(input logic pol, input logic pha);
      @(negedge clk);
      cpol  = pol;
      cpha  = pha;
      s_clk = pol;
      repeat (6) @(negedge clk);
   endtask

   task automatic tx_write(input logic [7:0] d);
      int n = 0;
      @(negedge clk);
      while (!tx_ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 2000) chk("tx_ready_timeout", 32'(tx_ready), 1);
      s_din    = d;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   task automatic ss_low();
      @(negedge clk);
      slave_select = 1'b0;
      half();
   endtask

   task automatic ss_high();
      half();
      slave_select = 1'b1;
      repeat (6) @(negedge clk);
   endtask

   // Master side: drives mosi, captures miso just before each sample edge.
   task automatic spi_word(input logic [7:0] mo, input logic [7:0] exp_mi,
                           input int nbits, output logic [7:0] mi);
      mi = '0;
      for (int i = 7; i > 7 - nbits; i--) begin
         if (!cpha) mosi = mo[i];
         else begin
            half();
            s_clk = ~cpol;
            mosi  = mo[i];
         end
         repeat (3) @(negedge clk);
         chk("miso_setup", 32'(miso), 32'(exp_mi[i]));
         @(negedge clk);
         mi[i] = miso;
         if (!cpha) begin
            s_clk = ~cpol;
            half();
         end
         s_clk = cpol;
      end
   endtask

   initial begin
      logic [7:0] mi, mi2;
      int         r0, u0;

      repeat (4) @(negedge clk);
      chk("rst_tx_ready", 32'(tx_ready), 1);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_miso", 32'(miso), 0);
      chk("rst_dout", 32'(s_dout), 0);
      chk("rst_rx_valid", 32'(rx_valid), 0);
      chk("rst_underrun", 32'(tx_underrun), 0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      for (int m = 0; m < 4; m++) begin
         set_mode(m[1], m[0]);
         tx_write(8'hA5);
         chk("mode_tx_ready_full", 32'(tx_ready), 0);
         r0 = rx_seen;
         u0 = und_seen;
         exp_rx.push_back(8'h3C);
         ss_low();
         chk("mode_busy", 32'(busy), 1);
         chk("mode_tx_ready_load", 32'(tx_ready), 1);
         spi_word(8'h3C, 8'hA5, 8, mi);
         ss_high();
         chk("mode_miso_word", 32'(mi), 32'hA5);
         chk("mode_rx_count", rx_seen - r0, 1);
         chk("mode_underrun_end", und_seen - u0, 1);
         chk("mode_dout_held", 32'(s_dout), 32'h3C);
         chk("mode_idle", 32'(busy), 0);
      end

      set_mode(1'b1, 1'b1);
      tx_write(8'hC3);
      r0 = rx_seen;
      u0 = und_seen;
      exp_rx.push_back(8'h11);
      exp_rx.push_back(8'h22);
      ss_low();
      fork
         begin
            spi_word(8'h11, 8'hC3, 8, mi);
            spi_word(8'h22, 8'h7E, 8, mi2);
         end
         begin
            tx_write(8'h7E);
            tx_write(8'h55);
         end
      join
      ss_high();
      chk("b2b_miso0", 32'(mi), 32'hC3);
      chk("b2b_miso1", 32'(mi2), 32'h7E);
      chk("b2b_rx_count", rx_seen - r0, 2);
      chk("b2b_underrun", und_seen - u0, 0);
      chk("b2b_tx_ready", 32'(tx_ready), 1);

      set_mode(1'b0, 1'b0);
      r0 = rx_seen;
      u0 = und_seen;
      exp_rx.push_back(8'hE7);
      ss_low();
      fork
         spi_word(8'hE7, 8'h00, 8, mi);
         tx_write(8'h5A);
      join
      ss_high();
      chk("und_miso_word", 32'(mi), 32'h00);
      chk("und_pulses", und_seen - u0, 1);
      chk("und_rx_count", rx_seen - r0, 1);
      chk("und_dout", 32'(s_dout), 32'hE7);

      tx_write(8'h5A);
      r0 = rx_seen;
      ss_low();
      spi_word(8'h81, 8'h5A, 5, mi);
      chk("abort_busy_pre", 32'(busy), 1);
      @(negedge clk);
      slave_select = 1'b1;
      repeat (4) @(negedge clk);
      chk("abort_busy", 32'(busy), 0);
      chk("abort_miso", 32'(miso), 0);
      repeat (6) @(negedge clk);
      chk("abort_no_rx", rx_seen - r0, 0);
      chk("abort_dout_kept", 32'(s_dout), 32'hE7);
      chk("abort_miso_bits", 32'(mi), 32'h58);
      tx_write(8'h3C);
      r0 = rx_seen;
      exp_rx.push_back(8'h96);
      ss_low();
      spi_word(8'h96, 8'h3C, 8, mi);
      ss_high();
      chk("post_abort_miso", 32'(mi), 32'h3C);
      chk("post_abort_rx", rx_seen - r0, 1);
      chk("post_abort_dout", 32'(s_dout), 32'h96);

      tx_write(8'h77);
      r0 = rx_seen;
      ss_low();
      spi_word(8'hF0, 8'h77, 3, mi);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("mrst_busy", 32'(busy), 0);
      chk("mrst_miso", 32'(miso), 0);
      chk("mrst_dout", 32'(s_dout), 0);
      chk("mrst_rx_valid", 32'(rx_valid), 0);
      chk("mrst_done", 32'(done_tick), 0);
      chk("mrst_underrun", 32'(tx_underrun), 0);
      chk("mrst_tx_ready", 32'(tx_ready), 1);
      @(negedge clk);
      slave_select = 1'b1;
      repeat (6) @(negedge clk);
      chk("mrst_no_rx", rx_seen - r0, 0);
      tx_write(8'hB4);
      exp_rx.push_back(8'h69);
      ss_low();
      spi_word(8'h69, 8'hB4, 8, mi);
      ss_high();
      chk("mrst_next_miso", 32'(mi), 32'hB4);
      chk("mrst_next_rx", rx_seen - r0, 1);
      chk("mrst_next_dout", 32'(s_dout), 32'h69);

      chk("rx_pending", exp_rx.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired: passed=%0d total=%0d", n_pass, n_chk);
      $fatal(1, "watchdog");
   end

endmodule
